mips_ifu_fq: RTL and testbench

- Parametrised instruction fetch unit with a decoupling fetch queue (FQ) between I-cache and ID.
- Handles variable-latency I-cache via request/ready/rvalid handshake; one fetch outstanding at a time.
- Static prediction on returned instructions: J/JAL always taken; conditional branches backward-taken/forward-not-taken.
- Handles EX-stage redirect (mispredict/JR/JALR) with queue flush and in-flight response drop.

---
 rtl/mips_ifu_fq.sv | 134 +++++++++++++
 tb/tb_mips_ifu_fq.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_ifu_fq.sv
// Instruction fetch unit: one-outstanding I-cache fetcher with static branch
// prediction, feeding a small circular fetch queue that decouples fetch from ID.
module mips_ifu_fq #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                FQ_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              I_req,
    output logic [ADDR_W-3:0] I_addr,
    input  logic              I_ready,
    input  logic              I_rvalid,
    input  logic [DATA_W-1:0] I_rdata,
    input  logic              ex_redirect,
    input  logic [ADDR_W-1:0] ex_redirect_pc,
    input  logic              id_ready,
    output logic              if2id_valid,
    output logic [DATA_W-1:0] if2id_inst,
    output logic [ADDR_W-1:0] if2id_pc,
    output logic              if2id_prdt_taken
);

    localparam int               PTR_W   = $clog2(FQ_DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [CNT_W-1:0]    r_cnt;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [DATA_W-1:0]   r_inst_mem [FQ_DEPTH];
    logic [ADDR_W-1:0]   r_pc_mem   [FQ_DEPTH];
    logic [FQ_DEPTH-1:0] r_prdt_mem;

    logic [5:0]          w_op;
    logic                w_is_jmp;
    logic                w_is_br;
    logic                w_prdt;
    logic [ADDR_W-1:0]   w_pc_incr;
    logic [ADDR_W-1:0]   w_jmp_tgt;
    logic [ADDR_W-1:0]   w_br_tgt;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic                w_full;
    logic                w_enq;
    logic                w_deq;

    // Issuing only from RUN with a free slot reserves that slot for the response.
    assign w_full = (r_cnt == DEPTH_C);
    assign I_req  = !rst && (r_state == S_RUN) && !ex_redirect && !w_full;
    assign I_addr = r_pc[ADDR_W-1:2];
    assign w_enq  = (r_state == S_WAIT) && I_rvalid && !ex_redirect;
    assign w_deq  = if2id_valid && id_ready && !ex_redirect;

    assign w_op      = I_rdata[31:26];
    assign w_is_jmp  = (w_op == 6'b000010) || (w_op == 6'b000011);
    assign w_is_br   = (w_op[5:2] == 4'b0001) || (w_op == 6'b000001);
    assign w_prdt    = w_is_jmp || (w_is_br && I_rdata[15]);
    assign w_pc_incr = r_pc + ADDR_W'(4);
    assign w_jmp_tgt = {w_pc_incr[ADDR_W-1:28], I_rdata[25:0], 2'b00};
    assign w_br_tgt  = w_pc_incr + {{(ADDR_W-18){I_rdata[15]}}, I_rdata[15:0], 2'b00};
    assign w_pc_nxt  = !w_prdt ? w_pc_incr : (w_is_jmp ? w_jmp_tgt : w_br_tgt);

    // A redirect in RUN masks I_req, so no request can be accepted alongside it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:   if (I_req && I_ready) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (I_rvalid)         w_state_nxt = S_RUN;
                else if (ex_redirect) w_state_nxt = S_DROP;
            end
            S_DROP:  if (I_rvalid) w_state_nxt = S_RUN;
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_RUN;
            r_pc     <= RESET_PC;
            r_cnt    <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (ex_redirect) begin
                r_pc     <= ex_redirect_pc;
                r_cnt    <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_enq) begin
                    r_pc     <= w_pc_nxt;
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_cnt <= r_cnt + CNT_W'(w_enq) - CNT_W'(w_deq);
            end
        end
    end

    // NOTE: storage is reset because the head outputs must read zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                r_inst_mem[i] <= '0;
                r_pc_mem[i]   <= '0;
            end
            r_prdt_mem <= '0;
        end else if (w_enq) begin
            r_inst_mem[r_wr_ptr] <= I_rdata;
            r_pc_mem[r_wr_ptr]   <= r_pc;
            r_prdt_mem[r_wr_ptr] <= w_prdt;
        end
    end

    assign if2id_valid      = (r_cnt != '0);
    assign if2id_inst       = r_inst_mem[r_rd_ptr];
    assign if2id_pc         = r_pc_mem[r_rd_ptr];
    assign if2id_prdt_taken = r_prdt_mem[r_rd_ptr];

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) w_enq |-> !w_full);

endmodule

// File: tb/tb_mips_ifu_fq.sv
// Scoreboard bench for mips_ifu_fq: a cache/ID model predicts the fetch stream,
// a separate monitor pops and compares every head entry ID consumes.
module tb_mips_ifu_fq;
    localparam int          ADDR_W   = 32;
    localparam int          DATA_W   = 32;
    localparam int          FQ_DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              I_req;
    logic [ADDR_W-3:0] I_addr;
    logic              I_ready = 1'b0;
    logic              I_rvalid = 1'b0;
    logic [DATA_W-1:0] I_rdata = '0;
    logic              ex_redirect = 1'b0;
    logic [ADDR_W-1:0] ex_redirect_pc = '0;
    logic              id_ready = 1'b0;
    logic              if2id_valid;
    logic [DATA_W-1:0] if2id_inst;
    logic [ADDR_W-1:0] if2id_pc;
    logic              if2id_prdt_taken;

    mips_ifu_fq #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FQ_DEPTH(FQ_DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst(rst),
        .I_req(I_req), .I_addr(I_addr), .I_ready(I_ready),
        .I_rvalid(I_rvalid), .I_rdata(I_rdata),
        .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
        .id_ready(id_ready),
        .if2id_valid(if2id_valid), .if2id_inst(if2id_inst),
        .if2id_pc(if2id_pc), .if2id_prdt_taken(if2id_prdt_taken)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        prdt;
    } entry_t;

    entry_t      exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] imem [logic [31:0]];
    bit          rand_mem = 0;

    // Cache model: kind 0 = live, 1 = killed by redirect, 2 = orphaned by reset.
    bit          out_valid = 0;
    int          out_kind = 0;
    int          out_lat = 0;
    logic [31:0] out_addr = '0;
    int          lat_fixed = 1;
    int          lat_max = 4;
    int          ready_mode = 1;
    int          idr_mode = 1;
    int          redir_rate = 0;
    bit          redir_req = 0;
    bit          redir_on_rv = 0;
    logic [31:0] redir_tgt = '0;
    logic [31:0] model_pc = RESET_PC;
    int          acc_cnt = 0;
    bit          popped = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [5:0]  bops [5] = '{6'b000001, 6'b000100, 6'b000101, 6'b000110, 6'b000111};
        int          sel = $urandom_range(0, 9);
        int          v = $urandom_range(0, 16) - 8;
        logic [15:0] imm = v[15:0];
        if (sel <= 3) return {6'b100011, 26'($urandom())};
        if (sel == 4) return {6'b000000, 5'($urandom()), 15'b0, 6'b001000};
        if (sel == 5) return {($urandom_range(0, 1) != 0) ? 6'b000011 : 6'b000010, 18'b0, 8'($urandom())};
        if (sel <= 7) return {bops[$urandom_range(0, 4)], 10'($urandom()), imm};
        return 32'h0;
    endfunction

    function automatic logic [31:0] get_inst(input logic [31:0] addr);
        if (imem.exists(addr)) return imem[addr];
        if (!rand_mem) return 32'h0;
        imem[addr] = rand_inst();
        return imem[addr];
    endfunction

    // Reference prediction: J/JAL taken, conditional branches taken when backward.
    function automatic entry_t expect_entry(input logic [31:0] pc, output logic [31:0] nxt);
        entry_t      e;
        logic [31:0] seq;
        int          op;
        e.inst = get_inst(pc);
        e.pc   = pc;
        e.prdt = 1'b0;
        seq    = pc + 32'd4;
        nxt    = seq;
        op     = int'(e.inst[31:26]);
        if (op == 2 || op == 3) begin
            e.prdt = 1'b1;
            nxt    = {seq[31:28], e.inst[25:0], 2'b00};
        end else if ((op >= 4 && op <= 7) || op == 1) begin
            if (e.inst[15]) begin
                e.prdt = 1'b1;
                nxt    = seq + 32'($signed(e.inst[15:0])) * 32'd4;
            end
        end
        return e;
    endfunction

    task automatic drive();
        logic rv = 1'b0;
        if (out_valid) begin
            if (out_lat > 0) out_lat--;
            rv = (out_lat == 0);
        end
        I_rvalid = rv;
        I_rdata  = rv ? get_inst(out_addr) : $urandom();
        if (out_valid && out_kind == 2) I_ready = 1'b0;
        else I_ready = (ready_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
        case (idr_mode)
            0:       id_ready = 1'b0;
            1:       id_ready = 1'b1;
            default: id_ready = ($urandom_range(0, 2) != 0);
        endcase
        ex_redirect = 1'b0;
        if (rst) begin
        end else if (redir_on_rv && rv) begin
            ex_redirect    = 1'b1;
            ex_redirect_pc = redir_tgt;
            id_ready       = 1'b1;
            redir_on_rv    = 0;
        end else if (redir_req) begin
            ex_redirect    = 1'b1;
            ex_redirect_pc = redir_tgt;
            redir_req      = 0;
        end else if (redir_rate > 0 && $urandom_range(1, redir_rate) == 1) begin
            ex_redirect    = 1'b1;
            ex_redirect_pc = {22'b0, 8'($urandom()), 2'b00};
        end
    endtask

    // Decides what happens at the coming edge from the stimulus already applied.
    task automatic evaluate();
        bit          exp_req;
        int          occ;
        logic [31:0] nxt;
        entry_t      e;
        if (rst) begin
            check("I_req_in_reset", I_req, 0);
            if (I_rvalid) out_valid = 0;
            popped = 0;
            return;
        end
        occ     = exp_q.size() + (popped ? 1 : 0);
        popped  = 0;
        exp_req = !ex_redirect && (occ < FQ_DEPTH) && !(out_valid && out_kind != 2);
        check("I_req", I_req, exp_req);
        if (ex_redirect) begin
            exp_q.delete();
            model_pc = ex_redirect_pc;
            if (out_valid) begin
                if (I_rvalid) out_valid = 0;
                else if (out_kind == 0) out_kind = 1;
            end
        end else begin
            if (out_valid && I_rvalid) begin
                if (out_kind == 0) begin
                    e = expect_entry(model_pc, nxt);
                    exp_q.push_back(e);
                    model_pc = nxt;
                end
                out_valid = 0;
            end
            if (I_req && I_ready) begin
                check("I_addr", I_addr, model_pc[31:2]);
                out_valid = 1;
                out_kind  = 0;
                out_addr  = {I_addr, 2'b00};
                out_lat   = (lat_fixed > 0) ? lat_fixed : $urandom_range(1, lat_max);
                acc_cnt++;
            end
        end
    endtask

    always begin
        @(posedge clk);
        #1 drive();
        @(negedge clk);
        #2 evaluate();
    end

    // Monitor: compares the FQ head against the scoreboard and retires consumed entries.
    always @(negedge clk) begin
        if (!rst) begin
            check("if2id_valid", if2id_valid, exp_q.size() != 0);
            if (if2id_valid && exp_q.size() != 0) begin
                check("if2id_inst", if2id_inst, exp_q[0].inst);
                check("if2id_pc", if2id_pc, exp_q[0].pc);
                check("if2id_prdt", if2id_prdt_taken, exp_q[0].prdt);
                if (id_ready && !ex_redirect) begin
                    void'(exp_q.pop_front());
                    popped = 1;
                end
            end
        end
    end

    task automatic issue_redirect(input logic [31:0] tgt);
        int n = 0;
        redir_tgt = tgt;
        redir_req = 1;
        while (redir_req && n < 20) begin
            @(posedge clk);
            n++;
        end
        check("redirect_issued", n < 20, 1);
    endtask

    initial begin
        int n;
        int c0;
        #1 rst = 1'b1;
        #1;
        check("reset_I_req", I_req, 0);
        check("reset_valid", if2id_valid, 0);
        check("reset_inst", if2id_inst, 0);
        check("reset_pc", if2id_pc, 0);
        check("reset_prdt", if2id_prdt_taken, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        // Sequential NOPs with a J 0x40 sitting at 0x10.
        imem[32'h10] = 32'h0800_0010;
        repeat (20) @(posedge clk);

        // Backward BNE at 0x20 (taken to 0x14), then forward BNE (falls through).
        imem[32'h20] = 32'h1400_FFFC;
        issue_redirect(32'h20);
        repeat (16) @(posedge clk);
        imem[32'h20] = 32'h1400_0004;
        issue_redirect(32'h20);
        repeat (10) @(posedge clk);

        // ID stalled: queue fills to depth, fetch stops, then drains in order.
        idr_mode = 0;
        issue_redirect(32'h0);
        repeat (20) @(posedge clk);
        check("full_hold_valid_req", {if2id_valid, I_req}, 2'b10);
        idr_mode = 1;
        repeat (12) @(posedge clk);

        // Slow cache, redirect two cycles after acceptance.
        lat_fixed = 5;
        c0 = acc_cnt;
        n = 0;
        while (acc_cnt == c0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("accept_seen", n < 50, 1);
        @(posedge clk);
        redir_tgt = 32'h100;
        redir_req = 1;
        repeat (25) @(posedge clk);

        // Redirect coincident with response and dequeue while all slots are committed.
        lat_fixed = 3;
        idr_mode = 0;
        issue_redirect(32'h200);
        n = 0;
        while (!(exp_q.size() == 3 && out_valid && out_kind == 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("fq_committed_full", n < 100, 1);
        redir_tgt = 32'h80;
        redir_on_rv = 1;
        n = 0;
        while (redir_on_rv && n < 20) begin
            @(posedge clk);
            n++;
        end
        check("coincident_redirect", n < 20, 1);
        idr_mode = 1;
        repeat (15) @(posedge clk);

        // Asynchronous reset with a fetch in flight; its late response must vanish.
        lat_fixed = 8;
        n = 0;
        while (!(out_valid && out_kind == 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("inflight_before_reset", n < 50, 1);
        #3 rst = 1'b1;
        exp_q.delete();
        model_pc = RESET_PC;
        if (out_valid) out_kind = 2;
        #1;
        check("async_reset_I_req", I_req, 0);
        check("async_reset_valid", if2id_valid, 0);
        check("async_reset_pc", if2id_pc, 0);
        check("async_reset_inst", if2id_inst, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        repeat (30) @(posedge clk);

        // Randomized traffic: random program, latency, stalls and redirects.
        rand_mem   = 1;
        lat_fixed  = 0;
        lat_max    = 4;
        ready_mode = 2;
        idr_mode   = 2;
        redir_rate = 25;
        repeat (3000) @(posedge clk);
        redir_rate = 0;
        idr_mode   = 1;
        repeat (40) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: no finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
